// File: rtl/pie_rx_decoder.sv
// Tag-side PIE receiver: recovers delimiter, data-0, RTcal, optional TRcal and data bits
// from the reader's serial line, delivering MSB-first bytes and frame-level pulses.
module pie_rx_decoder #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DELIM_MIN = 40,
    parameter int unsigned DELIM_MAX = 200,
    parameter int unsigned MIN_SYM   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic             frame_start,
    output logic [CNT_W-1:0] rtcal_len,
    output logic [CNT_W-1:0] trcal_len,
    output logic             trcal_seen,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic [3:0]       byte_bits,
    output logic [15:0]      bit_count,
    output logic             frame_end,
    output logic             err
);

    localparam logic [CNT_W-1:0] DelimMin = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] DelimMax = CNT_W'(DELIM_MAX);
    localparam logic [CNT_W-1:0] MinSym   = CNT_W'(MIN_SYM);

    typedef enum logic [2:0] {StIdle, StDelim, StD0, StRtcal, StSym, StEnd} state_e;

    state_e state_q, state_d;

    logic rx_s1, rx_s2, rx_prev;
    logic rise, fall;

    logic [CNT_W-1:0] cnt_q, cnt_d, lvl_q, lvl_d;
    logic [CNT_W-1:0] d0_len_q, d0_len_d, rtcal_q, rtcal_d, pivot_q, pivot_d;
    logic [CNT_W-1:0] trcal_q, trcal_d;
    logic             trcal_seen_q, trcal_seen_d, first_q, first_d;
    logic [7:0]       acc_q, acc_d, acc_new;
    logic [2:0]       fill_q, fill_d, bit_idx;
    logic [15:0]      bit_count_q, bit_count_d;
    logic             frame_start_q, frame_start_d, frame_end_q, frame_end_d;
    logic             err_q, err_d, byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic [3:0]       byte_bits_q, byte_bits_d;
    logic [CNT_W+1:0] hi_lim;
    logic             hi_to, lo_to_sym, lo_to_pre, cur_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rise = rx_s2 & ~rx_prev;
    assign fall = ~rx_s2 & rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            lvl_q         <= '0;
            d0_len_q      <= '0;
            rtcal_q       <= '0;
            pivot_q       <= '0;
            trcal_q       <= '0;
            trcal_seen_q  <= 1'b0;
            first_q       <= 1'b0;
            acc_q         <= '0;
            fill_q        <= '0;
            bit_count_q   <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            err_q         <= 1'b0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= '0;
            byte_bits_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lvl_q         <= lvl_d;
            d0_len_q      <= d0_len_d;
            rtcal_q       <= rtcal_d;
            pivot_q       <= pivot_d;
            trcal_q       <= trcal_d;
            trcal_seen_q  <= trcal_seen_d;
            first_q       <= first_d;
            acc_q         <= acc_d;
            fill_q        <= fill_d;
            bit_count_q   <= bit_count_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            err_q         <= err_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            byte_bits_q   <= byte_bits_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        d0_len_d      = d0_len_q;
        rtcal_d       = rtcal_q;
        pivot_d       = pivot_q;
        trcal_d       = trcal_q;
        trcal_seen_d  = trcal_seen_q;
        first_d       = first_q;
        acc_d         = acc_q;
        fill_d        = fill_q;
        bit_count_d   = bit_count_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        err_d         = 1'b0;
        byte_valid_d  = 1'b0;
        byte_data_d   = byte_data_q;
        byte_bits_d   = byte_bits_q;

        // cnt: cycles since last accepted rising edge; lvl: cycles at the current level
        if (state_q == StIdle) begin
            cnt_d = '0;
            lvl_d = '0;
        end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            lvl_d = (rise || fall) ? CNT_W'(1) : ((lvl_q == '1) ? lvl_q : lvl_q + CNT_W'(1));
        end

        // A TRcal may still be in flight during the first interval, so allow up to 3x RTcal high
        hi_lim    = first_q ? ({2'b00, rtcal_q} + {1'b0, rtcal_q, 1'b0}) : {2'b00, rtcal_q};
        hi_to     = rx_prev && ({2'b00, lvl_q} > hi_lim);
        lo_to_sym = !rx_prev && (lvl_q > rtcal_q);
        // RTcal is not known yet before the frame starts; bound low time by the delimiter limit
        lo_to_pre = !rx_prev && (lvl_q > DelimMax);

        cur_bit = (cnt_q >= pivot_q);
        bit_idx = 3'd7 - fill_q;
        acc_new = acc_q;
        acc_new[bit_idx] = cur_bit;

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StDelim;
                    cnt_d   = CNT_W'(1);
                    lvl_d   = CNT_W'(1);
                end
            end
            StDelim: begin
                if (rise) begin
                    if (cnt_q >= DelimMin && cnt_q <= DelimMax) begin
                        state_d = StD0;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StD0: begin
                if (lo_to_pre) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (rise) begin
                    if (cnt_q >= MinSym) begin
                        d0_len_d = cnt_q;
                        cnt_d    = CNT_W'(1);
                        state_d  = StRtcal;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StRtcal: begin
                if (lo_to_pre) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (rise) begin
                    if (cnt_q > d0_len_q) begin
                        rtcal_d       = cnt_q;
                        pivot_d       = cnt_q >> 1;
                        frame_start_d = 1'b1;
                        bit_count_d   = '0;
                        trcal_d       = '0;
                        trcal_seen_d  = 1'b0;
                        first_d       = 1'b1;
                        acc_d         = '0;
                        fill_d        = '0;
                        cnt_d         = CNT_W'(1);
                        state_d       = StSym;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StSym: begin
                if (hi_to) begin
                    if (fill_q != 3'd0) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = acc_q;
                        byte_bits_d  = {1'b0, fill_q};
                    end
                    state_d = StEnd;
                end else if (lo_to_sym) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (rise) begin
                    cnt_d   = CNT_W'(1);
                    first_d = 1'b0;
                    if (cnt_q < MinSym) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (first_q && cnt_q > rtcal_q) begin
                        trcal_d      = cnt_q;
                        trcal_seen_d = 1'b1;
                    end else begin
                        bit_count_d = (bit_count_q == 16'hFFFF) ? bit_count_q
                                                                : bit_count_q + 16'd1;
                        if (fill_q == 3'd7) begin
                            byte_valid_d = 1'b1;
                            byte_data_d  = acc_new;
                            byte_bits_d  = 4'd8;
                            acc_d        = '0;
                            fill_d       = '0;
                        end else begin
                            acc_d  = acc_new;
                            fill_d = fill_q + 3'd1;
                        end
                    end
                end
            end
            StEnd: begin
                frame_end_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign frame_start = frame_start_q;
    assign rtcal_len   = rtcal_q;
    assign trcal_len   = trcal_q;
    assign trcal_seen  = trcal_seen_q;
    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_bits   = byte_bits_q;
    assign bit_count   = bit_count_q;
    assign frame_end   = frame_end_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pie_rx_decoder.sv
// Bench for pie_rx_decoder: drives PIE frames and checks decoded output against a
// bit-list/byte-chunk reference model.
module tb_pie_rx_decoder;

    localparam int PW = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        frame_start, trcal_seen, byte_valid, frame_end, err;
    logic [15:0] rtcal_len, trcal_len, bit_count;
    logic [7:0]  byte_data;
    logic [3:0]  byte_bits;

    int n_vec = 0;
    int n_err = 0;

    int fs_cnt, fe_cnt, err_cnt;
    logic [7:0] got_data[$];
    logic [3:0] got_bits[$];
    logic [7:0] exp_data[$];
    logic [3:0] exp_bits[$];
    int ivals[$];
    int cur_rtcal;
    int exp_nbits;

    pie_rx_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .frame_start (frame_start),
        .rtcal_len   (rtcal_len),
        .trcal_len   (trcal_len),
        .trcal_seen  (trcal_seen),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_bits   (byte_bits),
        .bit_count   (bit_count),
        .frame_end   (frame_end),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_start) fs_cnt++;
        if (frame_end) fe_cnt++;
        if (err) err_cnt++;
        if (byte_valid) begin
            got_data.push_back(byte_data);
            got_bits.push_back(byte_bits);
        end
    end

    task automatic clear_mon();
        fs_cnt = 0;
        fe_cnt = 0;
        err_cnt = 0;
        got_data.delete();
        got_bits.delete();
        exp_data.delete();
        exp_bits.delete();
    endtask

    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic sym(input int ival);
        hold(1'b1, ival - PW);
        hold(1'b0, PW);
    endtask

    // Reference: interval >= RTcal/2 is a 1; bits packed MSB-first in groups of eight.
    function automatic void build_expected();
        bit bl[$];
        foreach (ivals[i]) bl.push_back(ivals[i] >= cur_rtcal / 2);
        for (int k = 0; k < bl.size(); k += 8) begin
            logic [7:0] b = 8'h00;
            int n = 0;
            for (int j = 0; j < 8; j++) begin
                if (k + j < bl.size()) begin
                    b[7-j] = bl[k+j];
                    n++;
                end
            end
            exp_data.push_back(b);
            exp_bits.push_back(4'(n));
        end
        exp_nbits = bl.size();
    endfunction

    task automatic send_frame(input int delim, input int d0, input int rtcal, input int trcal);
        cur_rtcal = rtcal;
        build_expected();
        hold(1'b1, 20);
        hold(1'b0, delim);
        sym(d0);
        sym(rtcal);
        if (trcal != 0) sym(trcal);
        foreach (ivals[i]) sym(ivals[i]);
        hold(1'b1, 3 * rtcal + 20);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if ({frame_start, byte_valid, frame_end, err, trcal_seen} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_pulses: got %b required 00000",
                     {frame_start, byte_valid, frame_end, err, trcal_seen});
        end
        n_vec++;
        if ({rtcal_len, trcal_len, bit_count} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_lens: got %h required 0", {rtcal_len, trcal_len, bit_count});
        end
        n_vec++;
        if ({byte_data, byte_bits} !== 12'h0) begin
            n_err++;
            $display("FAIL reset_byte: got %h required 0", {byte_data, byte_bits});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Frame checks are repeated inline in each scenario.
    task automatic test_spec_frames();
        int trc;
        for (int k = 0; k < 3; k++) begin
            int pat[$];
            clear_mon();
            ivals.delete();
            case (k)
                0: begin pat = '{1,0,0,0,0,0,0,0,1,0,1,1}; trc = 240; end
                1: begin pat = '{1,1,0,0,0,0,1,1}; trc = 0; end
                default: begin pat = '{60,59,59,60,60,60,59,60}; trc = 0; end
            endcase
            foreach (pat[i]) ivals.push_back(k == 2 ? pat[i] : (pat[i] != 0 ? 100 : 20));
            send_frame(80, 20, 120, trc);
            n_vec++;
            if (fs_cnt !== 1 || fe_cnt !== 1 || err_cnt !== 0) begin
                n_err++;
                $display("FAIL spec%0d_pulses: got fs=%0d fe=%0d err=%0d required 1 1 0",
                         k, fs_cnt, fe_cnt, err_cnt);
            end
            n_vec++;
            if (got_data.size() !== exp_data.size()) begin
                n_err++;
                $display("FAIL spec%0d_nbytes: got %0d required %0d",
                         k, got_data.size(), exp_data.size());
            end else begin
                foreach (exp_data[i]) begin
                    n_vec++;
                    if (got_data[i] !== exp_data[i] || got_bits[i] !== exp_bits[i]) begin
                        n_err++;
                        $display("FAIL spec%0d_byte%0d: got %h/%0d required %h/%0d", k, i,
                                 got_data[i], got_bits[i], exp_data[i], exp_bits[i]);
                    end
                end
            end
            n_vec++;
            if (rtcal_len !== 16'd120 || trcal_len !== 16'(trc) || trcal_seen !== (trc != 0)
                || bit_count !== 16'(exp_nbits)) begin
                n_err++;
                $display("FAIL spec%0d_lens: got rt=%0d tr=%0d seen=%0d bits=%0d required %0d %0d %0d %0d",
                         k, rtcal_len, trcal_len, trcal_seen, bit_count, 120, trc, trc != 0,
                         exp_nbits);
            end
        end
    endtask

    task automatic test_short_delim();
        clear_mon();
        hold(1'b1, 20);
        hold(1'b0, 20);
        hold(1'b1, 100);
        n_vec++;
        if (err_cnt !== 1 || fs_cnt !== 0) begin
            n_err++;
            $display("FAIL short_delim: got err=%0d fs=%0d required 1 0", err_cnt, fs_cnt);
        end
        clear_mon();
        ivals = '{100, 100, 20, 20, 20, 20, 100, 100};
        send_frame(50, 20, 120, 0);
        n_vec++;
        if (fs_cnt !== 1 || fe_cnt !== 1 || err_cnt !== 0 || got_data.size() !== 1) begin
            n_err++;
            $display("FAIL after_short_delim: got fs=%0d fe=%0d err=%0d nb=%0d required 1 1 0 1",
                     fs_cnt, fe_cnt, err_cnt, got_data.size());
        end else begin
            n_vec++;
            if (got_data[0] !== 8'hC3) begin
                n_err++;
                $display("FAIL after_short_delim_byte: got %h required c3", got_data[0]);
            end
        end
    endtask

    task automatic test_stuck_low();
        clear_mon();
        hold(1'b1, 20);
        hold(1'b0, 80);
        sym(20);
        sym(120);
        for (int i = 0; i < 5; i++) sym(i[0] ? 100 : 20);
        hold(1'b0, 300);
        hold(1'b1, 400);
        n_vec++;
        if (err_cnt !== 1 || fs_cnt !== 1 || fe_cnt !== 0 || got_data.size() !== 0) begin
            n_err++;
            $display("FAIL stuck_low: got err=%0d fs=%0d fe=%0d nb=%0d required 1 1 0 0",
                     err_cnt, fs_cnt, fe_cnt, got_data.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        hold(1'b1, 20);
        hold(1'b0, 80);
        sym(20);
        sym(120);
        sym(100);
        sym(20);
        sym(100);
        rx = 1'b1;
        reset = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({rtcal_len, bit_count, byte_data, trcal_seen} !== 41'h0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %h required 0",
                     {rtcal_len, bit_count, byte_data, trcal_seen});
        end
        reset = 1'b0;
        hold(1'b1, 400);
        n_vec++;
        if (fs_cnt !== 0 || fe_cnt !== 0 || err_cnt !== 0 || got_data.size() !== 0) begin
            n_err++;
            $display("FAIL reset_mid_pulses: got fs=%0d fe=%0d err=%0d nb=%0d required 0 0 0 0",
                     fs_cnt, fe_cnt, err_cnt, got_data.size());
        end
        clear_mon();
        ivals = '{100, 20, 100, 20, 100, 20, 100, 20, 100};
        send_frame(80, 20, 120, 0);
        n_vec++;
        if (fs_cnt !== 1 || fe_cnt !== 1 || got_data.size() !== 2) begin
            n_err++;
            $display("FAIL reset_mid_next: got fs=%0d fe=%0d nb=%0d required 1 1 2",
                     fs_cnt, fe_cnt, got_data.size());
        end else begin
            n_vec++;
            if (got_data[0] !== 8'hAA || got_data[1] !== 8'h80 || got_bits[1] !== 4'd1) begin
                n_err++;
                $display("FAIL reset_mid_next_bytes: got %h %h/%0d required aa 80/1",
                         got_data[0], got_data[1], got_bits[1]);
            end
        end
    endtask

    // nfr frames sent with no extra idle between them; checked as one run.
    task automatic test_random_frames(input int iters, input int nfr, input string tag);
        int d0, d1, rt, trc, delim, nbits;
        for (int it = 0; it < iters; it++) begin
            clear_mon();
            for (int f = 0; f < nfr; f++) begin
                d0 = $urandom_range(12, 30);
                d1 = d0 + $urandom_range(4, d0);
                rt = d0 + d1;
                trc = $urandom_range(0, 1) != 0 ? rt + $urandom_range(1, 2 * rt) : 0;
                delim = $urandom_range(40, 200);
                nbits = $urandom_range(0, 20);
                ivals.delete();
                for (int b = 0; b < nbits; b++) ivals.push_back($urandom_range(0, 1) != 0 ? d1 : d0);
                send_frame(delim, d0, rt, trc);
            end
            n_vec++;
            if (fs_cnt !== nfr || fe_cnt !== nfr || err_cnt !== 0) begin
                n_err++;
                $display("FAIL %s%0d_pulses: got fs=%0d fe=%0d err=%0d required %0d %0d 0",
                         tag, it, fs_cnt, fe_cnt, err_cnt, nfr, nfr);
            end
            n_vec++;
            if (got_data.size() !== exp_data.size()) begin
                n_err++;
                $display("FAIL %s%0d_nbytes: got %0d required %0d",
                         tag, it, got_data.size(), exp_data.size());
            end else begin
                foreach (exp_data[i]) begin
                    n_vec++;
                    if (got_data[i] !== exp_data[i] || got_bits[i] !== exp_bits[i]) begin
                        n_err++;
                        $display("FAIL %s%0d_byte%0d: got %h/%0d required %h/%0d", tag, it, i,
                                 got_data[i], got_bits[i], exp_data[i], exp_bits[i]);
                    end
                end
            end
            n_vec++;
            if (rtcal_len !== 16'(rt) || trcal_len !== 16'(trc) || trcal_seen !== (trc != 0)
                || bit_count !== 16'(exp_nbits)) begin
                n_err++;
                $display("FAIL %s%0d_lens: got rt=%0d tr=%0d seen=%0d bits=%0d required %0d %0d %0d %0d",
                         tag, it, rtcal_len, trcal_len, trcal_seen, bit_count, rt, trc, trc != 0,
                         exp_nbits);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_spec_frames();
        test_short_delim();
        test_stuck_low();
        test_reset_mid_frame();
        test_random_frames(10, 1, "rand");
        test_random_frames(3, 2, "b2b");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
